// File: rtl/sevseg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sevseg_pkg : segment type, hex glyph constants and blank pattern  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sevseg_pkg;

  typedef logic [6:0] seg_t;

  // Active-low, bit0 = a ... bit6 = g
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/hex_seg_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hex_seg_decoder : combinational nibble to active-low hex glyph     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hex_seg_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sevseg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sevseg_scan_driver : time-multiplexed common-anode 7-seg scanner   |
// | with leading-zero blanking; decimal point when SEVSEG_DP_EN is set |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
`ifdef SEVSEG_DP_EN
  ,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    seg_dp
`endif
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    lz_q;
  seg_t                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic       tick;
  logic [3:0] nibble;
  logic       zero_run;
  logic       lead_zero_sel;
  logic       blank;
  seg_t       glyph;

  always_comb begin
    shadow_d = load ? value : shadow_q;
    tick     = (pcnt_q == PCNT_LAST);
    pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Walk from the most significant digit down, tracking whether every
  // nibble from here upward is zero, and pick out the selected digit.
  always_comb begin
    nibble        = 4'h0;
    zero_run      = 1'b1;
    lead_zero_sel = 1'b0;
    an_d          = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (shadow_q[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k)) begin
        nibble        = shadow_q[4*k +: 4];
        lead_zero_sel = zero_run;
        an_d[k]       = 1'b0;
      end
    end
  end

  hex_seg_decoder u_dec (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    blank = lz_q & lead_zero_sel & (idx_q != '0);
    seg_d = blank ? SEG_BLANK : glyph;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      pcnt_q   <= '0;
      idx_q    <= '0;
      lz_q     <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      shadow_q <= shadow_d;
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      lz_q     <= lz_blank;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

`ifdef SEVSEG_DP_EN
  logic seg_dp_q, seg_dp_d;

  // Decimal point bypasses blanking on purpose.
  always_comb begin
    seg_dp_d = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        seg_dp_d = ~dp[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_dp_q <= 1'b1;
    end else begin
      seg_dp_q <= seg_dp_d;
    end
  end

  assign seg_dp = seg_dp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sevseg_scan_driver : directed scoreboard bench, 4 digits, div 4 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sevseg_scan_driver;

  localparam logic [6:0] G0  = 7'b1000000;
  localparam logic [6:0] G1  = 7'b1111001;
  localparam logic [6:0] G2  = 7'b0100100;
  localparam logic [6:0] G3  = 7'b0110000;
  localparam logic [6:0] G5  = 7'b0010010;
  localparam logic [6:0] GA  = 7'b0001000;
  localparam logic [6:0] GF  = 7'b0001110;
  localparam logic [6:0] GBL = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
`ifdef SEVSEG_DP_EN
  logic [3:0]  dp = 4'b0000;
  logic        seg_dp;
`endif

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] g12af   [4] = '{GF, GA, G2, G1};
  logic [6:0] g0030   [4] = '{G0, G3, GBL, GBL};
  logic [6:0] g0000lz [4] = '{G0, GBL, GBL, GBL};
  logic [6:0] g0005   [4] = '{G5, G0, G0, G0};

  sevseg_scan_driver #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .lz_blank (lz_blank),
    .seg      (seg),
    .an       (an)
`ifdef SEVSEG_DP_EN
    ,
    .dp       (dp),
    .seg_dp   (seg_dp)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] an_e, input logic [6:0] seg_e,
                          input logic dp_e, input string tag);
    exp_t e;
    e.an  = an_e;
    e.seg = seg_e;
    e.dp  = dp_e;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_tests++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty got 0 entries want 1");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_tests++;
      assert (an === e.an) else begin
        n_fail++;
        $error("FAIL %s an got %b want %b", e.tag, an, e.an);
      end
      n_tests++;
      assert (seg === e.seg) else begin
        n_fail++;
        $error("FAIL %s seg got %b want %b", e.tag, seg, e.seg);
      end
`ifdef SEVSEG_DP_EN
      n_tests++;
      assert (seg_dp === e.dp) else begin
        n_fail++;
        $error("FAIL %s seg_dp got %b want %b", e.tag, seg_dp, e.dp);
      end
`endif
    end
  endtask

  task automatic drive_check(input logic [3:0] an_e, input logic [6:0] seg_e,
                             input logic dp_e, input string tag);
    push_exp(an_e, seg_e, dp_e, tag);
    step();
    check_out();
  endtask

  // Leaves the bench #1 after the first edge with reset low (digit 0 phase, pcnt=1).
  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    push_exp(4'b1111, GBL, 1'b1, "reset");
    repeat (3) step();
    check_out();
    reset = 1'b0;
    drive_check(4'b1110, G0, 1'b1, "release");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and release
    do_reset();

    // Plain scan of 12AF
    value = 16'h12AF; load = 1'b1; lz_blank = 1'b0;
    drive_check(4'b1110, G0, 1'b1, "scan_load");
    load = 1'b0;
    for (int j = 2; j < 20; j++)
      drive_check(an_tab[(j/4)%4], g12af[(j/4)%4], 1'b1, "scan");

    // Leading-zero blanking
    value = 16'h0030; load = 1'b1; lz_blank = 1'b1;
    do_reset();
    value = 16'h0030; load = 1'b1;
    drive_check(4'b1110, G0, 1'b1, "lz_load");
    load = 1'b0;
    for (int j = 2; j < 18; j++)
      drive_check(an_tab[(j/4)%4], g0030[(j/4)%4], 1'b1, "lz_0030");
    value = 16'h0000; load = 1'b1;
    drive_check(4'b1110, G0, 1'b1, "lz_zero_load");
    load = 1'b0;
    for (int j = 19; j < 35; j++)
      drive_check(an_tab[(j/4)%4], g0000lz[(j/4)%4], 1'b1, "lz_0000");

    // Load on the same edge as the 0->1 tick
    lz_blank = 1'b0; value = 16'h0000;
    do_reset();
    drive_check(4'b1110, G0, 1'b1, "coll_pre1");
    drive_check(4'b1110, G0, 1'b1, "coll_pre2");
    value = 16'h0005; load = 1'b1;
    drive_check(4'b1110, G0, 1'b1, "coll_edge");
    load = 1'b0;
    drive_check(4'b1101, G0, 1'b1, "collision");
    for (int j = 5; j < 17; j++)
      drive_check(an_tab[(j/4)%4], g0005[(j/4)%4], 1'b1, "coll_after");

    // Reset while idx=2, pcnt=2
    do_reset();
    value = 16'h12AF; load = 1'b1;
    drive_check(4'b1110, G0, 1'b1, "mid_load");
    load = 1'b0;
    for (int j = 2; j < 10; j++)
      drive_check(an_tab[(j/4)%4], g12af[(j/4)%4], 1'b1, "mid_scan");
    reset = 1'b1; value = 16'hFFFF; load = 1'b1;
    drive_check(4'b1111, GBL, 1'b1, "mid_reset");
    reset = 1'b0; load = 1'b0;
    for (int j = 0; j < 5; j++)
      drive_check(an_tab[(j/4)%4], G0, 1'b1, "mid_restart");

`ifdef SEVSEG_DP_EN
    // Decimal point follows digit 2 only
    dp = 4'b0100; value = 16'h0000;
    do_reset();
    for (int j = 1; j < 17; j++)
      drive_check(an_tab[(j/4)%4], G0, ((j/4)%4 == 2) ? 1'b0 : 1'b1, "dp");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sevseg_scan_driver.md
# sevseg_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed hexadecimal value and scans it out one digit at a time onto a shared active-low segment bus, with a one-hot active-low anode select. Optional leading-zero blanking is available. It sits between the processor's display/debug register and the board's display pins, and replaces per-digit combinational decoders wired in parallel.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned; must be ≥ 1.
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  4*NUM_DIGITS  packed nibbles; nibble k = `value[4k+3:4k]` drives digit k; digit 0 is least significant.
- `load`  in  1  when 1 at a rising edge, `value` is captured into the shadow register.
- `lz_blank`  in  1  when 1, enables leading-zero blanking.
- `seg`  out  7  active-low segments, bit0 = a … bit6 = g.
- `an`  out  NUM_DIGITS  active-low one-hot digit enable.
- `dp`  in  NUM_DIGITS  per-digit decimal point (only with `SEVSEG_DP_EN`).
- `seg_dp`  out  1  active-low decimal point (only with `SEVSEG_DP_EN`).

## Operation
- **Shadow register**: `shadow <= value` on any edge with `load` = 1. Otherwise it holds. The display always reads `shadow`, never `value` directly.
- **Prescaler**: `pcnt` counts 0 … SCAN_DIV-1. At terminal count (`pcnt` = SCAN_DIV-1) it wraps to 0 and asserts an internal `tick`. With SCAN_DIV = 1, `tick` is asserted every cycle.
- **Digit index**: `idx` advances by 1 on `tick` and wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS = 1, `idx` stays 0.
- **Widths**:
  - `pcnt` is `$clog2(SCAN_DIV)` bits, minimum 1.
  - `idx` is `$clog2(NUM_DIGITS)` bits, minimum 1.
  - No truncation warnings are permitted.
- **Decode** (standard hex glyphs, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- **Leading-zero blanking** (`lz_blank` = 1):
  - Digit k is blanked if every nibble k … NUM_DIGITS-1 of `shadow` is zero and k ≠ 0.
  - A blanked digit drives `seg` = 1111111, and `an` is still asserted for its slot.
  - Digit 0 is never blanked, so a shadow value of 0 shows a single "0".
- **Outputs**:
  - `seg` and `an` are registered.
  - `an` = ~(1 << idx); exactly one bit is low outside reset.

## Timing
- **Reset**: `shadow` = 0, `pcnt` = 0, `idx` = 0, `an` = all ones (all digits off), `seg` = 1111111, `seg_dp` = 1.
- **First cycle after reset deasserts**: the output registers load idx 0. From the next cycle, `an` = …1110 and `seg` = 1000000.
- **Scan latency**: an `idx` change reaches `seg`/`an` one cycle later. Each digit is lit for exactly SCAN_DIV cycles. Full frame = NUM_DIGITS × SCAN_DIV cycles.
- **Load latency**: `load` at edge t updates `shadow` at t. The currently lit digit shows the new glyph at t+1. There is no wait for frame boundary.
- **`load` coinciding with `tick`**: both take effect. The newly selected digit shows the new `shadow` value.
- **Reset mid-scan**: reset overrides `load` and `tick`. All state returns to reset values in the same edge.
- `lz_blank` changes take effect with one-cycle latency, like `shadow`.

## Configuration
- **`SEVSEG_DP_EN` defined**: the `dp` input and `seg_dp` output exist. `seg_dp` = ~`dp[idx]`, registered alongside `seg`. Blanking does not suppress the decimal point.
- **`SEVSEG_DP_EN` undefined**: the ports are absent and no decimal-point logic is synthesised.

## Structure
- **Package `sevseg_pkg`** contains:
  - the 16 glyph constants;
  - `SEG_BLANK` = 7'b1111111;
  - a `seg_t` typedef (logic [6:0]).
- **Sub-module `hex_seg_decoder`**: combinational 4-bit → `seg_t` decoder using the package constants. It is instantiated once on the muxed nibble.
- **Top level** contains the prescaler, index counter, shadow register, blanking logic and output registers.

## Test plan
Bench configuration: NUM_DIGITS = 4, SCAN_DIV = 4.
1. **Reset**: hold `reset` 3 cycles → `an` = 1111, `seg` = 1111111. One cycle after release → `an` = 1110, `seg` = 1000000.
2. **Scan**: load 16'h12AF, `lz_blank` = 0 → every 4 cycles the display steps through:
   - `an` 1110 / `seg` 0001110
   - `an` 1101 / `seg` 0001000
   - `an` 1011 / `seg` 0100100
   - `an` 0111 / `seg` 1111001
   - then wraps back to 1110.
3. **Blanking**: load 16'h0030, `lz_blank` = 1 → digits 3 and 2 show `seg` 1111111, digit 1 shows 0110000, digit 0 shows 1000000. Load 16'h0000 → only digit 0 lit, showing 1000000.
4. **Load collision**: assert `load` with 16'h0005 on the same edge as the 0→1 `tick` → the next cycle shows `an` 1101 / `seg` 1000000. Digit 0 next shows 0010010.
5. **Reset mid-scan**: assert `reset` while `idx` = 2 and `pcnt` = 2 → the next cycle shows `an` 1111. After release, the scan restarts at digit 0 and the shadow value is 0.
6. **`SEVSEG_DP_EN`**: `dp` = 4'b0100 → `seg_dp` = 0 only while `an` = 1011; otherwise it is 1.
